fib_seq_ctrl: RTL
=================

Name: fib_seq_ctrl

Overview:
- Sequencer for a Fibonacci term generator: accepts a job request (term count), drives an internal a/b add-and-shift datapath, and streams the terms F0, F1, F2, … over a valid/ready interface with backpressure.
- Signals job completion with a one-cycle done pulse.
- Terminates the job early, with a sticky overflow flag, if the next term would not fit in WIDTH bits.
- Sits between a host/command block and downstream term consumers.

Parameters:
- WIDTH, 32, term width in bits.
- CNT_W, 8, width of the term-count and term-index fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- n_terms  input  CNT_W  number of terms to emit; sampled with start.
- busy  output  1  high in RUN and DONE.
- term_valid  output  1  term/term_idx/last are valid.
- term_ready  input  1  consumer accepts the term this cycle.
- term  output  WIDTH  current Fibonacci term.
- term_idx  output  CNT_W  index of the current term (0-based).
- last  output  1  current term is the final term of the job.
- done  output  1  one-cycle pulse at job end.
- ovf  output  1  job ended early on overflow; sticky until the next accepted start.

Behaviour:
- Reset values: state=IDLE; busy, term_valid, term, term_idx, last, done, ovf all 0.
- rst overrides everything, including mid-job and a start in the same cycle. The cycle after rst is IDLE with all outputs 0. No done pulse for the aborted job.
- Internal state: a (WIDTH bits) holds the current term. b (WIDTH+1 bits) holds the next term; b[WIDTH]=1 means the next term overflowed. cnt holds the latched n_terms.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1, n_terms>0 → latch cnt=n_terms, a=0, b=1, idx=0, clear ovf; go to RUN.
  - start=1, n_terms=0 → clear ovf; go to DONE. No terms are emitted.
  - start=0 → remain in IDLE.
- RUN:
  - term_valid=1, term=a, term_idx=idx.
  - last = (idx==cnt-1) OR b[WIDTH] (combinational from registered state).
  - Handshake fires when term_valid AND term_ready.
  - Without a handshake, term, term_idx and last stay stable, and term_valid stays high.
  - Handshake with last=0 → a<=b[WIDTH-1:0], b<=a+b (WIDTH+1-bit add, zero-extended a), idx<=idx+1.
  - Handshake with last=1 → go to DONE. If b[WIDTH]=1 and idx!=cnt-1, set ovf=1. When both conditions hold on the same term, the count takes precedence: ovf=0.
- DONE:
  - done=1 and term_valid=0 for exactly one cycle, then go to IDLE.
  - ovf is valid in this cycle and holds afterwards.
- start is ignored outside IDLE.
- Latency:
  - Start accepted at edge k → first term valid in cycle k+1.
  - With term_ready held high, one term per cycle.
  - Last handshake at edge m → done high in cycle m+1 → IDLE in cycle m+2.
  - A new start is accepted no earlier than cycle m+2.
- Max n_terms = 2^CNT_W−1. idx never wraps, because last is reached first.

Test Plan:
- Reset, then start with n_terms=10 and term_ready=1 → terms 0,1,1,2,3,5,8,13,21,34 on consecutive cycles with idx 0..9; last only at idx 9; done one cycle later; ovf=0; busy low after done.
- Backpressure: n_terms=6, drop term_ready for 3 cycles while idx=2 → term=1 and idx=2 held stable with term_valid=1; sequence resumes with 2,3,5; exactly 6 handshakes; no term skipped or duplicated.
- Overflow, WIDTH=8, n_terms=20 → 14 terms ending in 233 at idx 13, with last=1 there; done with ovf=1. Then start with n_terms=3 → ovf clears; terms 0,1,1.
- Edge counts:
  - n_terms=1 → a single term 0 with last=1, then done.
  - n_terms=0 → done pulse the cycle after start, term_valid never high, ovf=0.
- Start while busy, pulsed at idx 4 with a different n_terms → ignored; the original job completes unchanged.
- Mid-job reset: assert rst for one cycle at idx 5, with start also high → the next cycle is IDLE with all outputs 0 and no done pulse. A new start with n_terms=4 → terms 0,1,1,2.

Source files
------------

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl
// Sequencer for a Fibonacci term generator. A host requests a job of
// n_terms terms. The block then streams F0, F1, F2, ... over a
// valid/ready interface that honours backpressure, and pulses done
// once the job ends. If the next term would not fit in WIDTH bits, the
// job ends early on the last representable term and the sticky ovf
// flag is raised.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       job request, only looked at while idle
//   n_terms     number of terms to emit, captured together with start
//   busy        high while a job is running or finishing (RUN, DONE)
//   term_valid  term / term_idx / last carry a valid term
//   term_ready  consumer takes the presented term this cycle
//   term        current Fibonacci term
//   term_idx    0-based index of the current term
//   last        current term is the final one of this job
//   done        one-cycle pulse at the end of a job
//   ovf         job ended early on overflow; held until the next start
module fib_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [WIDTH-1:0] term,
  output logic [CNT_W-1:0] term_idx,
  output logic             last,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   B_INIT  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH:0]   b;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic             ovf_q;

  logic             at_count;
  logic             last_int;

  // a holds the current term and b holds the next one. The extra top bit
  // of b marks a next term that no longer fits in WIDTH bits. That makes
  // the current term the final one, even if the count is not reached.
  // cnt is never zero while in RUN, so cnt-1 does not underflow here.
  assign at_count = (idx == (cnt - CNT_ONE));
  assign last_int = at_count | b[WIDTH];

  // Outputs are decoded only from registered state. The term fields are
  // forced to zero outside RUN, so idle and post-reset outputs read as 0.
  assign busy       = (state != IDLE);
  assign term_valid = (state == RUN);
  assign term       = term_valid ? a   : '0;
  assign term_idx   = term_valid ? idx : '0;
  assign last       = term_valid & last_int;
  assign done       = (state == DONE);
  assign ovf        = ovf_q;

  // Single control FSM with its datapath.
  // IDLE accepts a job. A zero-length job goes straight to DONE, so the
  // host still sees a done pulse. RUN advances a/b by one Fibonacci step
  // on every non-final handshake and holds everything while the
  // consumer stalls. The final handshake moves to DONE. There, ovf is
  // raised only if the overflow cut the job short of its count; when the
  // count ends on the same term, the job is treated as complete. DONE
  // lasts exactly one cycle. Reset has priority over any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
      idx   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ovf_q <= 1'b0;
            if (n_terms != '0) begin
              cnt   <= n_terms;
              a     <= '0;
              b     <= B_INIT;
              idx   <= '0;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (term_ready) begin
            if (last_int) begin
              ovf_q <= b[WIDTH] & ~at_count;
              state <= DONE;
            end else begin
              a   <= b[WIDTH-1:0];
              b   <= {1'b0, a} + b;
              idx <= idx + CNT_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
